stone_drawer: RTL and testbench

STONE_DRAWER -- requirements
Module: stone_drawer

---
 rtl/stone_drawer.sv | 162 ++++++++++++++++
 tb/tb_stone_drawer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stone_drawer.sv
// stone_drawer: walks stone RAM entries 1..quantity-1 and draws each visible
// entry as a 16x16 block of pixels. Colour follows the entry type.
//
// Optional feature macro: STONE_ROUND_CORNER_EN
//   defined   -> the four corner pixels of each block are not plotted
//   undefined -> full 16x16 square
// The cycle count is the same in both builds. Only the plot strobe changes.
//
// RAM read data layout (synchronous RAM):
//   X=[31:23], Y=[18:11], type=[3:2], visible=[1], moving=[0].
//
// debug_state exposes the FSM state encoding so that checkers can follow it.
module stone_drawer (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  quantity,
  input  logic [31:0] ram_q,
  output logic        draw_stone_flag,
  output logic [3:0]  draw_index,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        done,
  output logic [2:0]  debug_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WAIT1 = 3'd2,
    S_WAIT2 = 3'd3,
    S_EVAL  = 3'd4,
    S_PLOT  = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t      state, next_state;
  logic [3:0]  idx;
  logic [3:0]  qty;
  logic [7:0]  cnt;
  logic [8:0]  ent_x;
  logic [7:0]  ent_y;
  logic [1:0]  ent_type;
  logic        ent_vis;

  logic [8:0]  px;
  logic [7:0]  py;
  logic        in_range;
  logic        corner;

  // The moving bit and the spare fields do not affect drawing.
  // A carried item is still drawn.
  logic unused_ram_bits;
  assign unused_ram_bits = ^{ram_q[22:19], ram_q[10:4], ram_q[0]};

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state logic
  // RAM data is valid after the address has been held for two cycles
  // (CHECK then WAIT1). WAIT2 captures the entry.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CHECK;
      S_CHECK: next_state = (idx >= qty) ? S_DONE : S_WAIT1;
      S_WAIT1: next_state = S_WAIT2;
      S_WAIT2: next_state = S_EVAL;
      S_EVAL:  next_state = ent_vis ? S_PLOT : S_NEXT;
      S_PLOT:  if (cnt == 8'd255) next_state = S_NEXT;
      S_NEXT:  next_state = S_CHECK;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: index, quantity latch, pixel counter and entry capture
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idx      <= 4'd0;
      qty      <= 4'd0;
      cnt      <= 8'd0;
      ent_x    <= 9'd0;
      ent_y    <= 8'd0;
      ent_type <= 2'd0;
      ent_vis  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx <= 4'd1;
            qty <= quantity;
          end
        end
        S_WAIT2: begin
          ent_x    <= ram_q[31:23];
          ent_y    <= ram_q[18:11];
          ent_type <= ram_q[3:2];
          ent_vis  <= ram_q[1];
        end
        S_EVAL:  if (ent_vis) cnt <= 8'd0;
        S_PLOT:  if (cnt != 8'd255) cnt <= cnt + 8'd1;
        // qty is at most 15, so idx cannot wrap past it.
        S_NEXT:  idx <= idx + 4'd1;
        default: ;
      endcase
    end
  end

  // Pixel coordinates wrap naturally at the 9-bit and 8-bit widths.
  assign px       = ent_x + {5'd0, cnt[3:0]};
  assign py       = ent_y + {4'd0, cnt[7:4]};
  assign in_range = (px <= 9'd319) && (py <= 8'd239);

`ifdef STONE_ROUND_CORNER_EN
  assign corner = (cnt == 8'd0) || (cnt == 8'd15) || (cnt == 8'd240) || (cnt == 8'd255);
`else
  assign corner = 1'b0;
`endif

  // Output decode
  // Outputs depend only on registered state, so they drop to zero as soon
  // as reset is asserted.
  always_comb begin
    draw_stone_flag = 1'b0;
    draw_index      = 4'd0;
    vga_x           = 9'd0;
    vga_y           = 8'd0;
    vga_colour      = 3'd0;
    vga_plot        = 1'b0;
    done            = 1'b0;
    case (state)
      S_CHECK, S_WAIT1, S_WAIT2, S_EVAL, S_NEXT: begin
        draw_stone_flag = 1'b1;
        draw_index      = idx;
      end
      S_PLOT: begin
        draw_stone_flag = 1'b1;
        draw_index      = idx;
        vga_x           = px;
        vga_y           = py;
        case (ent_type)
          2'b00:   vga_colour = 3'b111;
          2'b01:   vga_colour = 3'b110;
          default: vga_colour = 3'b011;
        endcase
        vga_plot = in_range && !corner;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign debug_state = state;

endmodule

// File: tb/tb_stone_drawer.sv
// Bench for stone_drawer.
// A synchronous RAM model feeds ram_q.
// Each pass pushes its expected pixels {x,y,colour} into exp_q.
// A monitor pops and compares every plotted pixel.
module tb_stone_drawer;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [3:0]  quantity;
  logic [31:0] ram_q;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        done;
  logic [2:0]  debug_state;

  logic [31:0] ram [16];
  logic [19:0] exp_q[$];

  int checks;
  int errors;
  int done_count;
  int flag_cycles;
  int plot_count;

  stone_drawer dut (
    .clock           (clock),
    .resetn          (resetn),
    .start           (start),
    .quantity        (quantity),
    .ram_q           (ram_q),
    .draw_stone_flag (draw_stone_flag),
    .draw_index      (draw_index),
    .vga_x           (vga_x),
    .vga_y           (vga_y),
    .vga_colour      (vga_colour),
    .vga_plot        (vga_plot),
    .done            (done),
    .debug_state     (debug_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM model
  always @(posedge clock) ram_q <= ram[draw_index];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [8:0] x, input logic [7:0] y,
                                     input logic [1:0] t, input logic v, input logic m);
    logic [31:0] w;
    w = $urandom;
    w[31:23] = x;
    w[18:11] = y;
    w[3:2]   = t;
    w[1]     = v;
    w[0]     = m;
    return w;
  endfunction

  // Reference model: the pixels one entry should produce, in plot order
  function automatic void push_entry(input int i);
    logic [8:0] px;
    logic [7:0] py;
    logic [2:0] col;
    logic       skip;
    if (ram[i][1]) begin
      case (ram[i][3:2])
        2'b00:   col = 3'b111;
        2'b01:   col = 3'b110;
        default: col = 3'b011;
      endcase
      for (int c = 0; c < 256; c++) begin
        px = ram[i][31:23] + 9'(c % 16);
        py = ram[i][18:11] + 8'(c / 16);
        skip = 1'b0;
`ifdef STONE_ROUND_CORNER_EN
        if (c == 0 || c == 15 || c == 240 || c == 255) skip = 1'b1;
`endif
        if (px <= 9'd319 && py <= 8'd239 && !skip) exp_q.push_back({px, py, col});
      end
    end
  endfunction

  // Monitor and scoreboard, sampled away from the active edge
  always @(negedge clock) begin
    if (resetn) begin
      if (draw_stone_flag) flag_cycles++;
      if (done) done_count++;
      if (vga_plot) begin
        plot_count++;
        if (exp_q.size() == 0) check_eq("extra_pixel", {12'd0, vga_x, vga_y, vga_colour}, 32'd0);
        else check_eq("pixel", {12'd0, vga_x, vga_y, vga_colour}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic run_pass(input logic [3:0] q, input bit pulse_mid, input string tag);
    int exp_cyc, cyc, d0, n_exp;
    bit got;
    exp_cyc = 1;
    for (int i = 1; i < int'(q); i++) begin
      push_entry(i);
      exp_cyc += ram[i][1] ? 261 : 5;
    end
    n_exp = exp_q.size();
    @(negedge clock);
    quantity    = q;
    start       = 1'b1;
    d0          = done_count;
    flag_cycles = 0;
    plot_count  = 0;
    @(posedge clock);
    #1;
    start    = 1'b0;
    quantity = 4'($urandom_range(0, 15));
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 5000) begin
      @(posedge clock);
      cyc++;
      #1;
      if (done) got = 1'b1;
      else if (pulse_mid && cyc > 20 && cyc < 200 && (cyc % 7) == 0) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(got), 32'd1);
    check_eq({tag, "_cycles"}, cyc, exp_cyc);
    repeat (4) @(negedge clock);
    check_eq({tag, "_done_count"}, done_count - d0, 32'd1);
    check_eq({tag, "_flag_cycles"}, flag_cycles, exp_cyc);
    check_eq({tag, "_plot_count"}, plot_count, n_exp);
    check_eq({tag, "_queue_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Stimulus
  initial begin
    int d0;
    checks = 0;
    errors = 0;
    done_count = 0;
    flag_cycles = 0;
    plot_count = 0;
    resetn = 1'b0;
    start = 1'b0;
    quantity = 4'd0;
    for (int i = 0; i < 16; i++) ram[i] = mk(9'd0, 8'd0, 2'b00, 1'b0, 1'b0);

    #1;
    check_eq("rst_flag", 32'(draw_stone_flag), 32'd0);
    check_eq("rst_index", 32'(draw_index), 32'd0);
    check_eq("rst_plot", 32'(vga_plot), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_state", 32'(debug_state), 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Gold item (moving bit set, still drawn) followed by an invisible entry
    ram[1] = mk(9'd100, 8'd50, 2'b01, 1'b1, 1'b1);
    ram[2] = mk(9'd7, 8'd9, 2'b00, 1'b0, 1'b0);
    run_pass(4'd3, 1'b0, "gold");

    // Empty passes
    run_pass(4'd1, 1'b0, "qty1");
    run_pass(4'd0, 1'b0, "qty0");

    // Clipped at the screen edge
    ram[1] = mk(9'd310, 8'd230, 2'b10, 1'b1, 1'b0);
    run_pass(4'd2, 1'b0, "clip");

    // Start pulses while plotting must be ignored
    ram[1] = mk(9'd20, 8'd30, 2'b00, 1'b1, 1'b0);
    run_pass(4'd2, 1'b1, "restart_ignored");

    // Random table including wrap-around coordinates
    for (int i = 1; i < 16; i++)
      ram[i] = mk(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run_pass(4'd15, 1'b0, "random");

    // Reset in the middle of PLOT
    ram[1] = mk(9'd0, 8'd0, 2'b00, 1'b1, 1'b0);
    push_entry(1);
    @(negedge clock);
    d0 = done_count;
    quantity = 4'd2;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (40) @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    check_eq("mid_rst_flag", 32'(draw_stone_flag), 32'd0);
    check_eq("mid_rst_index", 32'(draw_index), 32'd0);
    check_eq("mid_rst_x", 32'(vga_x), 32'd0);
    check_eq("mid_rst_y", 32'(vga_y), 32'd0);
    check_eq("mid_rst_colour", 32'(vga_colour), 32'd0);
    check_eq("mid_rst_plot", 32'(vga_plot), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_state", 32'(debug_state), 32'd0);
    repeat (5) @(negedge clock);
    exp_q.delete();
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    check_eq("mid_rst_no_done", done_count - d0, 32'd0);
    run_pass(4'd2, 1'b0, "redraw");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
